random_multi: RTL and testbench
===============================

Name: random_multi

Overview:
- Parametrised successor to the single-channel 32-bit seedable random source used by the simulation core.
- Holds NUM_CH independent Galois LFSRs of WIDTH bits, loaded from one shared seed with per-channel salt.
- Adds an advance enable, zero-state protection, a warm-up discard phase after every (re)seed, and a bounded output in [0, range) per channel.
- Feeds per-agent random decisions, one channel per consumer.

Parameters:
- WIDTH, 32: LFSR state and output width per channel (8..64).
- NUM_CH, 4: number of independent channels (1..16).
- TAPS, 32'h80200003: Galois feedback mask, WIDTH bits; default is maximal-length for 32 bits.
- CH_SALT, 32'h9E3779B9: per-channel seed salt, WIDTH bits.
- WARMUP, 16: forced advances after a seed load before output is valid (0..255).
- DEFAULT_SEED, 32'h1: seed applied on Reset.

Ports:
- Clk  in  1  system clock, all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- LD_seed  in  1  load seed into all channels; priority over en.
- seed  in  WIDTH  seed value, sampled while LD_seed=1.
- en  in  1  advance all channels by one step (RUN state only).
- range  in  WIDTH  upper bound for bounded outputs, shared by all channels.
- value  out  NUM_CH*WIDTH  raw LFSR states, channel i at [i*WIDTH +: WIDTH], registered.
- bounded  out  NUM_CH*WIDTH  per-channel (value_i*range)>>WIDTH, combinational from value.
- valid  out  1  1 in RUN; value/bounded usable.
- busy  out  1  1 in WARMUP.

Behaviour:
- Step function: if state[0]=1, next = (state>>1) ^ TAPS; otherwise next = state>>1.
- Channel load value: L_i = S ^ (i*CH_SALT), with the product truncated to WIDTH bits. If L_i==0, load 1 instead. Channel 0 therefore loads S unchanged.
- States:
  - WARMUP: every channel steps every cycle regardless of en. An 8-bit counter counts completed steps. On the edge where the count reaches WARMUP, go to RUN.
  - RUN: every channel steps on each edge with en=1 and holds when en=0.
- Reset=1: load with S=DEFAULT_SEED, clear counter. Enter WARMUP, or RUN if WARMUP=0.
  - Reset has priority over LD_seed and en.
  - Reset asserted mid-warmup or mid-run aborts that phase.
- LD_seed=1 (any state): load with S=seed, clear counter, state=WARMUP (or RUN if WARMUP=0).
  - If LD_seed is held for multiple cycles, reload on every cycle. Warm-up stepping starts on the first edge after LD_seed falls.
  - LD_seed during WARMUP restarts the count from 0.
- Outputs: valid=(state==RUN), busy=(state==WARMUP), both registered.
  - Reset values: valid=0, busy=1 (valid=1, busy=0 if WARMUP=0). value=the loaded DEFAULT_SEED pattern.
  - value always reflects the current registers, including during WARMUP. Consumers must gate on valid.
- bounded: full 2*WIDTH-bit unsigned product, upper WIDTH bits taken. range=0 gives 0. The result is always < range for range>0.
- Zero state is unreachable: loads are guarded, and a maximal TAPS never steps a nonzero state to zero.

Test Plan:
- WARMUP=0, NUM_CH=1, seed=1, LD_seed high for 1 cycle, then en=1 -> value sequence on successive edges: 0x00000001, 0x80200003, 0xC0300002, 0x60180001. valid=1 from the load edge.
- WARMUP=0, range=6, states 0x80200003 then 0xC0300002 -> bounded=3 then 4. With range=0 -> bounded=0.
- Defaults, seed=0x71AD92C0 (1907200704) loaded -> ch0=0x71AD92C0, ch1=0xEF9AEB79 at the load edge. Zero-seed load -> ch0=1.
- Defaults, 1-cycle LD_seed -> busy=1 and valid=0 for exactly 16 edges, stepping even with en=0. Then valid=1, busy=0, and ch0 equals the 16th successor of seed.
- In RUN, en=0 for 5 cycles -> value constant. LD_seed pulsed at warm-up count 10 -> count restarts, 16 more edges before valid.
- Reset asserted for 1 cycle mid-RUN with LD_seed=1 and en=1 -> DEFAULT_SEED pattern loaded, valid=0, busy=1. Identical subsequent sequence to power-on.

Source files
------------

// File: rtl/random_multi.sv
// Multi-channel seedable Galois LFSR source with a warm-up discard phase after every seed
// load and a per-channel bounded output in [0, range).

module random_lane #(
  parameter int                WIDTH   = 32,
  parameter int                IDX     = 0,
  parameter logic [WIDTH-1:0]  TAPS    = WIDTH'(32'h80200003),
  parameter logic [WIDTH-1:0]  CH_SALT = WIDTH'(32'h9E3779B9)
) (
  input  logic             Clk,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [WIDTH-1:0] i_range,
  output logic [WIDTH-1:0] o_val,
  output logic [WIDTH-1:0] o_bnd
);
  localparam logic [WIDTH-1:0] SALT = WIDTH'(CH_SALT * IDX);

  logic [WIDTH-1:0]   r_state;
  logic [WIDTH-1:0]   w_ld;
  logic [WIDTH-1:0]   w_ld_g;
  logic [WIDTH-1:0]   w_next;
  logic [2*WIDTH-1:0] w_prod;

  // A zero load would lock the LFSR, so it is replaced with 1.
  assign w_ld   = i_seed ^ SALT;
  assign w_ld_g = (w_ld == '0) ? WIDTH'(1) : w_ld;
  assign w_next = r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);

  always_ff @(posedge Clk) begin
    if (i_load)      r_state <= w_ld_g;
    else if (i_step) r_state <= w_next;
  end

  // Upper half of the full product scales the state into [0, range).
  assign w_prod = {{WIDTH{1'b0}}, r_state} * {{WIDTH{1'b0}}, i_range};
  assign o_val  = r_state;
  assign o_bnd  = WIDTH'(w_prod >> WIDTH);
endmodule

module random_multi #(
  parameter int                WIDTH        = 32,
  parameter int                NUM_CH       = 4,
  parameter logic [WIDTH-1:0]  TAPS         = WIDTH'(32'h80200003),
  parameter logic [WIDTH-1:0]  CH_SALT      = WIDTH'(32'h9E3779B9),
  parameter int                WARMUP       = 16,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = WIDTH'(32'h1)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    LD_seed,
  input  logic [WIDTH-1:0]        seed,
  input  logic                    en,
  input  logic [WIDTH-1:0]        range,
  output logic [NUM_CH*WIDTH-1:0] value,
  output logic [NUM_CH*WIDTH-1:0] bounded,
  output logic                    valid,
  output logic                    busy
);
  typedef enum logic {S_WARMUP, S_RUN} state_t;

  localparam logic [7:0] WU      = 8'(WARMUP);
  localparam state_t     LOAD_ST = (WARMUP == 0) ? S_RUN : S_WARMUP;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_valid;
  logic       r_busy;

  logic                           w_load;
  logic                           w_step;
  logic [WIDTH-1:0]               w_seed;
  logic [NUM_CH-1:0][WIDTH-1:0]   w_val;
  logic [NUM_CH-1:0][WIDTH-1:0]   w_bnd;

  // Reset is just a load of DEFAULT_SEED that also outranks LD_seed.
  assign w_load = Reset | LD_seed;
  assign w_seed = Reset ? DEFAULT_SEED : seed;
  assign w_step = !w_load && ((r_state == S_WARMUP) || en);

  always_ff @(posedge Clk) begin
    if (w_load) begin
      r_state <= LOAD_ST;
      r_cnt   <= '0;
      r_valid <= (WARMUP == 0);
      r_busy  <= (WARMUP != 0);
    end else if (r_state == S_WARMUP) begin
      r_cnt <= r_cnt + 8'd1;
      if (r_cnt + 8'd1 == WU) begin
        r_state <= S_RUN;
        r_valid <= 1'b1;
        r_busy  <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    random_lane #(
      .WIDTH   (WIDTH),
      .IDX     (g),
      .TAPS    (TAPS),
      .CH_SALT (CH_SALT)
    ) u_lane (
      .Clk     (Clk),
      .i_load  (w_load),
      .i_step  (w_step),
      .i_seed  (w_seed),
      .i_range (range),
      .o_val   (w_val[g]),
      .o_bnd   (w_bnd[g])
    );
  end

  assign value   = w_val;
  assign bounded = w_bnd;
  assign valid   = r_valid;
  assign busy    = r_busy;
endmodule

// File: tb/tb_random_multi.sv
// Directed bench: a single-channel no-warm-up instance and a default four-channel instance.

module tb_random_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_ld, a_en, a_valid, a_busy;
  logic [31:0] a_seed, a_rng, a_val, a_bnd;

  logic         b_rst, b_ld, b_en, b_valid, b_busy;
  logic [31:0]  b_seed, b_rng;
  logic [127:0] b_val, b_bnd;

  int checks = 0;
  int errors = 0;

  random_multi #(.WIDTH(32), .NUM_CH(1), .WARMUP(0)) u_a (
    .Clk(clk), .Reset(a_rst), .LD_seed(a_ld), .seed(a_seed), .en(a_en), .range(a_rng),
    .value(a_val), .bounded(a_bnd), .valid(a_valid), .busy(a_busy)
  );

  random_multi u_b (
    .Clk(clk), .Reset(b_rst), .LD_seed(b_ld), .seed(b_seed), .en(b_en), .range(b_rng),
    .value(b_val), .bounded(b_bnd), .valid(b_valid), .busy(b_busy)
  );

  function automatic logic [31:0] stp(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
  endfunction

  function automatic logic [127:0] mdl(input logic [31:0] s, input int n);
    logic [127:0] r;
    logic [31:0]  c;
    logic [31:0]  salt;
    salt = 32'h9E3779B9;
    for (int i = 0; i < 4; i++) begin
      c = s ^ 32'(salt * i);
      if (c == 32'h0) c = 32'h1;
      for (int k = 0; k < n; k++) c = stp(c);
      r[i*32 +: 32] = c;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1; a_ld = 0; a_en = 0; a_seed = 0; a_rng = 0;
    b_rst = 1; b_ld = 0; b_en = 0; b_seed = 0; b_rng = 0;
    tick();
    chk("a_rst_val", a_val, 32'h1);
    chk("a_rst_vb", {a_valid, a_busy}, 2'b10);
    chk("b_rst_val", b_val, {32'hDAA66D2A, 32'h3C6EF373, 32'h9E3779B8, 32'h00000001});
    chk("b_rst_vb", {b_valid, b_busy}, 2'b01);

    // No-warm-up instance: raw sequence and bounded scaling
    a_rst = 0; b_rst = 0;
    a_ld = 1; a_seed = 32'h1;
    tick();
    chk("a_ld_val", a_val, 32'h1);
    chk("a_ld_valid", {a_valid, a_busy}, 2'b10);
    a_ld = 0; a_en = 1; a_rng = 6;
    tick();
    chk("a_s1", a_val, 32'h80200003);
    chk("a_b1", a_bnd, 32'd3);
    tick();
    chk("a_s2", a_val, 32'hC0300002);
    chk("a_b2", a_bnd, 32'd4);
    tick();
    chk("a_s3", a_val, 32'h60180001);
    a_rng = 0; #1;
    chk("a_b_rng0", a_bnd, 32'd0);
    a_en = 0;
    repeat (5) tick();
    chk("a_hold", a_val, 32'h60180001);

    // Default instance: salted load and warm-up length
    b_ld = 1; b_seed = 32'h71AD92C0;
    tick();
    chk("b_ld_ch0", b_val[31:0], 32'h71AD92C0);
    chk("b_ld_ch1", b_val[63:32], 32'hEF9AEB79);
    chk("b_ld_vb", {b_valid, b_busy}, 2'b01);
    b_ld = 0; b_en = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("b_wu_busy", {b_valid, b_busy}, 2'b01);
    end
    tick();
    chk("b_wu_done", {b_valid, b_busy}, 2'b10);
    chk("b_wu_val", b_val, mdl(32'h71AD92C0, 16));
    repeat (5) tick();
    chk("b_run_hold", b_val, mdl(32'h71AD92C0, 16));
    b_en = 1;
    repeat (2) tick();
    chk("b_run_en", b_val, mdl(32'h71AD92C0, 18));
    b_rng = 32'h10; #1;
    chk("b_bnd_ch0", b_bnd[31:0], 32'(mdl(32'h71AD92C0, 18) >> 28) & 32'hF);
    b_en = 0;

    // LD_seed mid-warm-up restarts the count
    b_ld = 1; b_seed = 32'h12345678;
    tick();
    b_ld = 0;
    repeat (10) tick();
    chk("b_mid_busy", {b_valid, b_busy}, 2'b01);
    b_ld = 1; b_seed = 32'hCAFEF00D;
    tick();
    b_ld = 0;
    repeat (15) tick();
    chk("b_rs_busy", {b_valid, b_busy}, 2'b01);
    tick();
    chk("b_rs_done", {b_valid, b_busy}, 2'b10);
    chk("b_rs_val", b_val, mdl(32'hCAFEF00D, 16));

    // Held LD_seed reloads every cycle; zero seed guarded on channel 0
    b_ld = 1; b_seed = 32'h0; b_en = 1;
    repeat (3) tick();
    chk("b_zero_ch0", b_val[31:0], 32'h1);
    chk("b_zero_ch1", b_val[63:32], 32'h9E3779B9);
    chk("b_hold_ld_vb", {b_valid, b_busy}, 2'b01);
    b_ld = 0;
    repeat (16) tick();
    chk("b_zero_run", b_val, mdl(32'h0, 16));
    tick();

    // Reset mid-run outranks LD_seed/en and replays the power-on sequence
    b_rst = 1; b_ld = 1; b_en = 1; b_seed = 32'h55;
    tick();
    chk("b_rst2_val", b_val, {32'hDAA66D2A, 32'h3C6EF373, 32'h9E3779B8, 32'h00000001});
    chk("b_rst2_vb", {b_valid, b_busy}, 2'b01);
    b_rst = 0; b_ld = 0; b_en = 0;
    repeat (16) tick();
    chk("b_rst2_done", {b_valid, b_busy}, 2'b10);
    chk("b_rst2_seq", b_val, mdl(32'h1, 16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
